// File: rtl/ntt_pkg.sv
// Shared constants, FSM state type and modular helper for the Kyber NTT-domain multiply slice.
package ntt_pkg;

  localparam int KYBER_Q     = 3329;
  localparam int N_PAIRS_DEF = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ntt_mult_state_t;

  // Operands are reduced before the product so 32-bit arithmetic never overflows.
  function automatic logic [31:0] mul_mod_q(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] xr;
    logic [31:0] yr;
    xr = x % KYBER_Q;
    yr = y % KYBER_Q;
    return (xr * yr) % KYBER_Q;
  endfunction

endpackage

// File: rtl/base_case_multiply.sv
// Kyber base-case product of two degree-1 polynomials mod (X^2 - gamma), reduced mod q.
// Purely combinational: zero latency, no flow control.
module base_case_multiply
  import ntt_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic [CW-1:0] a0,
  input  logic [CW-1:0] a1,
  input  logic [CW-1:0] b0,
  input  logic [CW-1:0] b1,
  input  logic [CW-1:0] gamma,
  output logic [CW-1:0] c0,
  output logic [CW-1:0] c1
);

  logic [31:0] a0_w, a1_w, b0_w, b1_w, g_w;
  logic [31:0] c0_w, c1_w;

  assign a0_w = 32'(a0);
  assign a1_w = 32'(a1);
  assign b0_w = 32'(b0);
  assign b1_w = 32'(b1);
  assign g_w  = 32'(gamma);

  // c0 = a0*b0 + a1*b1*gamma, c1 = a0*b1 + a1*b0; each partial term is already < q.
  assign c0_w = (mul_mod_q(a0_w, b0_w) + mul_mod_q(mul_mod_q(a1_w, b1_w), g_w)) % KYBER_Q;
  assign c1_w = (mul_mod_q(a0_w, b1_w) + mul_mod_q(a1_w, b0_w)) % KYBER_Q;

  assign c0 = CW'(c0_w);
  assign c1 = CW'(c1_w);

endmodule

// File: rtl/ntt_mult_seq.sv
// Sequential pointwise NTT multiply: streams N_PAIRS pairs through one base_case_multiply.
// Read-to-write latency 2 cycles, done N_PAIRS+3 cycles after start; no backpressure, start ignored while busy.
module ntt_mult_seq
  import ntt_pkg::*;
#(
  parameter int N_PAIRS = N_PAIRS_DEF,
  parameter int CW      = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [6:0]      rd_addr,
  input  logic [2*CW-1:0] f_pair,
  input  logic [2*CW-1:0] g_pair,
  input  logic [CW-1:0]   zeta,
  output logic            wr_en,
  output logic [6:0]      wr_addr,
  output logic [2*CW-1:0] wr_data
);

  localparam int               CNT_W     = $clog2(N_PAIRS);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(N_PAIRS - 1);
  localparam logic [6:0]       LAST_ADDR = 7'(N_PAIRS - 1);

  ntt_mult_state_t  state;
  logic [CNT_W-1:0] rd_cnt;
  logic             vld;
  logic [6:0]       pair_idx;
  logic [CW-1:0]    c0;
  logic [CW-1:0]    c1;

  base_case_multiply #(
    .CW(CW)
  ) u_bcm (
    .a0   (f_pair[CW-1:0]),
    .a1   (f_pair[2*CW-1:CW]),
    .b0   (g_pair[CW-1:0]),
    .b1   (g_pair[2*CW-1:CW]),
    .gamma(zeta),
    .c0   (c0),
    .c1   (c1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      rd_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= '0;
            rd_cnt  <= '0;
          end
        end
        RUN: begin
          // rd_cnt holds at the last index so the address never wraps.
          if (rd_cnt == LAST_CNT) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            rd_cnt  <= rd_cnt + CNT_W'(1);
            rd_addr <= 7'(rd_cnt + CNT_W'(1));
          end
        end
        DRAIN: begin
          if (wr_en && (wr_addr == LAST_ADDR)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          rd_en <= 1'b0;
        end
      endcase
    end
  end

  // Read data arrives one cycle after rd_en; the product is registered straight into the write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld      <= 1'b0;
      pair_idx <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      vld      <= rd_en;
      pair_idx <= rd_addr;
      wr_en    <= vld;
      if (vld) begin
        wr_addr <= pair_idx;
        wr_data <= {c1, c0};
      end
    end
  end

endmodule

// File: tb/tb_ntt_mult_seq.sv
// Self-checking bench for ntt_mult_seq: RAM/ROM model, write log, and a Kyber base-case reference.
module tb_ntt_mult_seq;

  localparam int N  = 128;
  localparam int CW = 16;
  localparam int Q  = 3329;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            busy, done, rd_en, wr_en;
  logic [6:0]      rd_addr, wr_addr;
  logic [2*CW-1:0] f_pair = '0;
  logic [2*CW-1:0] g_pair = '0;
  logic [CW-1:0]   zeta   = '0;
  logic [2*CW-1:0] wr_data;

  logic [CW-1:0] f_mem [2*N];
  logic [CW-1:0] g_mem [2*N];
  logic [CW-1:0] z_mem [N];
  int            exp_h [N];

  int wq_addr[$];
  int wq_data[$];
  int wq_cyc[$];
  int done_q[$];
  int rise_q[$];

  int checks = 0;
  int errors = 0;

  ntt_mult_seq #(.N_PAIRS(N), .CW(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .f_pair (f_pair),
    .g_pair (g_pair),
    .zeta   (zeta),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: data appears the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      f_pair <= {f_mem[2*rd_addr+1], f_mem[2*rd_addr]};
      g_pair <= {g_mem[2*rd_addr+1], g_mem[2*rd_addr]};
      zeta   <= z_mem[rd_addr];
    end
  end

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // mode 0: all ones with zeta 17; mode 1: random in [0,q); mode 2: all q-1
  task automatic fill(input int mode);
    for (int i = 0; i < 2*N; i++) begin
      case (mode)
        0:       begin f_mem[i] = 16'd1;    g_mem[i] = 16'd1;    end
        1:       begin f_mem[i] = 16'($urandom_range(0, Q-1)); g_mem[i] = 16'($urandom_range(0, Q-1)); end
        default: begin f_mem[i] = 16'd3328; g_mem[i] = 16'd3328; end
      endcase
    end
    for (int j = 0; j < N; j++) begin
      case (mode)
        0:       z_mem[j] = 16'd17;
        1:       z_mem[j] = 16'($urandom_range(0, Q-1));
        default: z_mem[j] = 16'd3328;
      endcase
    end
    for (int j = 0; j < N; j++) begin
      longint f0, f1, g0, g1, z, r0, r1;
      f0 = longint'(f_mem[2*j]);   f1 = longint'(f_mem[2*j+1]);
      g0 = longint'(g_mem[2*j]);   g1 = longint'(g_mem[2*j+1]);
      z  = longint'(z_mem[j]);
      r0 = (f0*g0 + f1*g1*z) % Q;
      r1 = (f0*g1 + f1*g0) % Q;
      exp_h[j] = int'(r1 * 65536 + r0);
    end
  endtask

  // Cycle c is the c-th cycle after the clock edge that samples start.
  task automatic run_collect(input int ncyc, input int hold_until, input int p1, input int p2,
                             input int rst_cyc);
    logic prev_rd;
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); done_q.delete(); rise_q.delete();
    prev_rd = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      if (c == rst_cyc) begin
        reset = 1'b1;
        #1;
        chk("rst_mid_busy",    int'(busy),    0);
        chk("rst_mid_done",    int'(done),    0);
        chk("rst_mid_rd_en",   int'(rd_en),   0);
        chk("rst_mid_rd_addr", int'(rd_addr), 0);
        chk("rst_mid_wr_en",   int'(wr_en),   0);
        chk("rst_mid_wr_addr", int'(wr_addr), 0);
        chk("rst_mid_wr_data", int'(wr_data), 0);
      end
      if (wr_en) begin
        wq_addr.push_back(int'(wr_addr));
        wq_data.push_back(int'(wr_data));
        wq_cyc.push_back(c);
      end
      if (done) done_q.push_back(c);
      if (rd_en && !prev_rd) rise_q.push_back(c);
      prev_rd = rd_en;
      start = (c < hold_until) || (c == p1) || (c == p2);
      if (c == rst_cyc + 1) reset = 1'b0;
    end
    start = 1'b0;
  endtask

  // Run r starts N+4 cycles after run r-1 when start is held.
  task automatic check_writes(input string tag, input int nexp, input int ndone, input int nrise,
                              input int bound_chk);
    chk({tag, "_wr_count"}, wq_addr.size(), nexp);
    for (int i = 0; i < wq_addr.size() && i < nexp; i++) begin
      int j, r, d;
      j = i % N;
      r = i / N;
      d = wq_data[i];
      chk({tag, "_wr_addr"}, wq_addr[i], j);
      chk({tag, "_wr_data"}, d, exp_h[j]);
      chk({tag, "_wr_cycle"}, wq_cyc[i], 3 + r*(N+4) + j);
      if (bound_chk != 0) begin
        chk({tag, "_c0_below_q"}, int'((d & 32'hFFFF) < Q), 1);
        chk({tag, "_c1_below_q"}, int'(((d >> 16) & 32'hFFFF) < Q), 1);
      end
    end
    chk({tag, "_done_count"}, done_q.size(), ndone);
    for (int k = 0; k < done_q.size() && k < ndone; k++)
      chk({tag, "_done_cycle"}, done_q[k], (N+3) + k*(N+4));
    chk({tag, "_rd_start_count"}, rise_q.size(), nrise);
    for (int k = 0; k < rise_q.size() && k < nrise; k++)
      chk({tag, "_rd_start_cycle"}, rise_q[k], 1 + k*(N+4));
    chk({tag, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",    int'(busy),    0);
    chk("reset_done",    int'(done),    0);
    chk("reset_rd_en",   int'(rd_en),   0);
    chk("reset_rd_addr", int'(rd_addr), 0);
    chk("reset_wr_en",   int'(wr_en),   0);
    chk("reset_wr_addr", int'(wr_addr), 0);
    chk("reset_wr_data", int'(wr_data), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Unit coefficients: every pair gives {c1,c0} = {2,18}.
    run_collect(N+8, 1, -1, -1, -1);
    check_writes("ones", N, 1, 1, 0);
    if (wq_data.size() > 0) chk("ones_literal", wq_data[0], 32'h0002_0012);

    for (int t = 0; t < 2; t++) begin
      fill(1);
      run_collect(N+8, 1, -1, -1, -1);
      check_writes("random", N, 1, 1, 1);
    end

    fill(2);
    run_collect(N+8, 1, -1, -1, -1);
    check_writes("boundary", N, 1, 1, 1);

    // Extra start pulses while busy must not restart or queue a run.
    fill(1);
    run_collect(N+8, 1, 5, 60, -1);
    check_writes("start_busy", N, 1, 1, 0);

    // Reset in cycle 40 kills the run: only the writes from cycles 3..39 appear.
    fill(1);
    run_collect(N+8, 1, -1, -1, 40);
    check_writes("rst_run", 37, 0, 1, 0);
    run_collect(N+8, 1, -1, -1, -1);
    check_writes("after_rst", N, 1, 1, 0);

    // start held high: two back-to-back runs, then idle.
    fill(1);
    run_collect(2*(N+4)+8, 200, -1, -1, -1);
    check_writes("held_start", 2*N, 2, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
